// File: rtl/rgbw_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : rgbw_pwm_bank
// Description : Multi-channel PWM bank with double-buffered duties and
//               run-time edge/centre-aligned modulation.
// Revision    : 1.0 - initial release
// ============================================================================
module rgbw_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      center_mode,
    input  logic [PRESC_W-1:0]        presc,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_we,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      update_pending
);

    localparam logic [WIDTH-1:0] C_MAX  = '1;
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [PRESC_W-1:0]  r_pcnt;
    logic [WIDTH-1:0]    r_cnt;
    logic                r_dir_down;
    logic                r_mode;
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [WIDTH-1:0]    r_active [CHANNELS];
    logic                r_pending;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;

    logic                w_tick;
    logic                w_boundary;
    logic [WIDTH-1:0]    w_cnt_nxt;
    logic                w_dir_nxt;
    logic [WIDTH-1:0]    w_duty [CHANNELS];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_duty[i] = duty_in[i*WIDTH +: WIDTH];
        end
    end

    // >= rather than == so a lowered reload mid-count ticks at once
    assign w_tick     = (r_pcnt >= presc);
    assign w_boundary = enable && w_tick &&
                        (r_mode ? (r_dir_down && (r_cnt == C_ONE)) : (r_cnt == C_MAX));

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir_down;
        if (w_tick) begin
            if (!r_mode) begin
                w_cnt_nxt = r_cnt + C_ONE;
            end else if (!r_dir_down) begin
                if (r_cnt == C_MAX) begin
                    w_cnt_nxt = C_MAX - C_ONE;
                    w_dir_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end else begin
                if (r_cnt == C_ZERO) begin
                    w_cnt_nxt = C_ONE;
                    w_dir_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
        end
        // Every period restarts counting up, whichever mode gets latched
        if (!r_mode || w_boundary) begin
            w_dir_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt         <= '0;
            r_cnt          <= '0;
            r_dir_down     <= 1'b0;
            r_mode         <= 1'b0;
            r_pending      <= 1'b0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pwm[i] <= enable && (r_cnt < r_active[i]);
                if (duty_we) begin
                    r_shadow[i] <= w_duty[i];
                end
                if (!enable) begin
                    r_active[i] <= r_shadow[i];
                end else if (w_boundary) begin
                    r_active[i] <= duty_we ? w_duty[i] : r_shadow[i];
                end
            end

            if (!enable) begin
                r_pcnt         <= '0;
                r_cnt          <= '0;
                r_dir_down     <= 1'b0;
                r_mode         <= center_mode;
                r_pending      <= 1'b0;
                r_period_start <= 1'b0;
            end else begin
                r_pcnt         <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
                r_cnt          <= w_cnt_nxt;
                r_dir_down     <= w_dir_nxt;
                r_period_start <= w_boundary;
                if (w_boundary) begin
                    r_mode    <= center_mode;
                    r_pending <= 1'b0;
                end else if (duty_we) begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign pwm_out        = r_pwm;
    assign period_start   = r_period_start;
    assign update_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rgbw_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgbw_pwm_bank
// Description : Self-checking bench for rgbw_pwm_bank against a period-phase
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgbw_pwm_bank;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int PW  = 8;
    localparam int MAX = (1 << W) - 1;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            center_mode;
    logic [PW-1:0]   presc;
    logic [CH*W-1:0] duty_in;
    logic            duty_we;
    logic [CH-1:0]   pwm_out;
    logic            period_start;
    logic            update_pending;

    rgbw_pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .center_mode    (center_mode),
        .presc          (presc),
        .duty_in        (duty_in),
        .duty_we        (duty_we),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: position within the current period plus duty buffers
    int m_pcnt, m_phase;
    bit m_mode, m_pending;
    int m_shadow [CH];
    int m_active [CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pcnt = 0; m_phase = 0; m_mode = 0; m_pending = 0;
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    function automatic int duty_of(input int i);
        logic [CH*W-1:0] v;
        v = duty_in;
        return int'(v[i*W +: W]);
    endfunction

    function automatic int period_len();
        return m_mode ? 2 * MAX : MAX + 1;
    endfunction

    function automatic bit next_is_boundary();
        return enable && (m_pcnt >= int'(presc)) && (m_phase == period_len() - 1);
    endfunction

    task automatic set_duty(input int i, input int v);
        duty_in[i*W +: W] = W'(v);
    endtask

    // One clock: advance the model, clock the DUT, compare all outputs
    task automatic step();
        logic [CH-1:0] e_pwm;
        bit e_ps, tick, bnd;
        int cnt;
        e_pwm = '0;
        e_ps  = 0;
        if (!enable) begin
            m_pcnt = 0; m_phase = 0; m_mode = center_mode; m_pending = 0;
            for (int i = 0; i < CH; i++) begin
                m_active[i] = m_shadow[i];
                if (duty_we) m_shadow[i] = duty_of(i);
            end
        end else begin
            cnt = (m_mode && m_phase > MAX) ? 2 * MAX - m_phase : m_phase;
            for (int i = 0; i < CH; i++) e_pwm[i] = (cnt < m_active[i]);
            tick = (m_pcnt >= int'(presc));
            bnd  = tick && (m_phase == period_len() - 1);
            e_ps = bnd;
            if (tick) m_phase = (m_phase + 1) % period_len();
            m_pcnt = tick ? 0 : (m_pcnt + 1) % (1 << PW);
            if (bnd) begin
                m_mode = center_mode;
                m_pending = 0;
                if (bnd) m_phase = 0;
                for (int i = 0; i < CH; i++) begin
                    if (duty_we) m_shadow[i] = duty_of(i);
                    m_active[i] = m_shadow[i];
                end
            end else if (duty_we) begin
                m_pending = 1;
                for (int i = 0; i < CH; i++) m_shadow[i] = duty_of(i);
            end
        end
        @(posedge clk);
        #1;
        duty_we = 1'b0;
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("period_start", 32'(period_start), 32'(e_ps));
        chk("update_pending", 32'(update_pending), 32'(m_pending));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Clocks until the next period_start pulse (bounded)
    task automatic wait_start(input int limit, output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!period_start && waited < limit);
    endtask

    task automatic check_period(input string tag, input int exp);
        int w;
        wait_start(4 * exp, w);
        wait_start(4 * exp, w);
        chk(tag, 32'(w), 32'(exp));
    endtask

    task automatic count_ch0(input int n, output int high);
        high = 0;
        for (int k = 0; k < n; k++) begin
            step();
            high += int'(pwm_out[0]);
        end
    endtask

    task automatic goto_boundary(input string tag);
        int k;
        k = 0;
        while (!next_is_boundary() && k < 4000) begin
            step();
            k++;
        end
        chk(tag, 32'(next_is_boundary()), 32'd1);
    endtask

    initial begin
        int h, w;
        rst_n = 1'b0; enable = 1'b0; center_mode = 1'b0; presc = '0;
        duty_in = '0; duty_we = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_ps", 32'(period_start), 32'd0);
        chk("reset_pend", 32'(update_pending), 32'd0);
        rst_n = 1'b1;

        // Edge mode, duty 64 loaded while disabled
        for (int i = 0; i < CH; i++) set_duty(i, $urandom_range(0, MAX));
        set_duty(0, 64);
        duty_we = 1'b1;
        run(3);
        enable = 1'b1;
        run(20);
        count_ch0(256, h);
        chk("edge_duty64_high", 32'(h), 32'd64);
        check_period("edge_period", 256);

        // Double buffer: mid-period write stays pending until boundary
        run(100);
        set_duty(0, 200);
        duty_we = 1'b1;
        step();
        chk("db_pending", 32'(update_pending), 32'd1);
        wait_start(600, w);
        count_ch0(256, h);
        chk("db_new_high", 32'(h), 32'd200);

        // Collision: write lands exactly on the boundary tick
        goto_boundary("coll_reach");
        set_duty(0, 10);
        duty_we = 1'b1;
        step();
        chk("coll_ps", 32'(period_start), 32'd1);
        count_ch0(256, h);
        chk("coll_high", 32'(h), 32'd10);

        // Centre-aligned, switched mid-period
        set_duty(0, 100);
        duty_we = 1'b1;
        center_mode = 1'b1;
        run(50);
        check_period("centre_period", 510);
        run(700);

        // Prescaler
        center_mode = 1'b0;
        presc = 8'd3;
        run(1100);
        check_period("presc3_period", 1024);
        presc = 8'd200;
        h = 0;
        while (m_pcnt != 150 && h < 400) begin
            step();
            h++;
        end
        chk("presc_reach150", 32'(m_pcnt), 32'd150);
        presc = 8'd2;
        run(40);
        presc = 8'd0;
        run(600);

        // Duty limits
        set_duty(0, 0);
        set_duty(1, MAX);
        duty_we = 1'b1;
        step();
        wait_start(600, w);
        count_ch0(256, h);
        chk("duty0_high", 32'(h), 32'd0);
        h = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            h += int'(!pwm_out[1]);
        end
        chk("duty_max_low", 32'(h), 32'd1);

        // Disabled hold
        enable = 1'b0;
        run(20);
        chk("disabled_pwm", 32'(pwm_out), 32'd0);
        enable = 1'b1;

        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            enable = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 299) == 0) center_mode = ~center_mode;
            if ($urandom_range(0, 39) == 0) begin
                duty_in = CH*W'($urandom());
                duty_we = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) presc = PW'($urandom_range(0, 3));
            step();
        end

        // Asynchronous reset mid-period
        enable = 1'b1;
        center_mode = 1'b0;
        presc = '0;
        for (int i = 0; i < CH; i++) set_duty(i, MAX);
        duty_we = 1'b1;
        run(700);
        chk("pre_reset_pwm", 32'(pwm_out), 32'hF);
        rst_n = 1'b0;
        #2;
        chk("async_reset_pwm", 32'(pwm_out), 32'd0);
        chk("async_reset_pend", 32'(update_pending), 32'd0);
        chk("async_reset_ps", 32'(period_start), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b0;
        model_reset();
        run(5);
        enable = 1'b1;
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
